// File: rtl/data_memory_load_unit_pkg.sv
// Shared definitions for the data memory load unit: word type, funct3
// load-type codes, load FSM states and small decode helpers.
package data_memory_load_unit_pkg;

    typedef logic [31:0] word_t;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD0  = 2'b01,
        RD1  = 2'b10
    } load_state_e;

    // Unsupported funct3 encodings behave as a full-word load.
    function automatic logic [2:0] decode_load_type(input logic [2:0] lt);
        case (lt)
            LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU: return lt;
            default:                             return LT_LW;
        endcase
    endfunction

    // True when the bytes of the access cross into the next word.
    function automatic logic load_spans(input logic [2:0] lt, input logic [1:0] offset);
        case (lt)
            LT_LH, LT_LHU: return (offset == 2'd3);
            LT_LW:         return (offset != 2'd0);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_load_format.sv
// Combinational load formatter: shifts the two-word window right by the
// byte offset, then sign/zero-extends according to the (decoded) load type.
module data_memory_load_format
    import data_memory_load_unit_pkg::*;
(
    input  word_t      word0_i,
    input  word_t      word1_i,
    input  logic [1:0] offset_i,
    input  logic [2:0] load_type_i,
    output word_t      value_o
);

    logic [63:0] pair_s;
    logic [31:0] shifted_s;

    assign pair_s    = {word1_i, word0_i};
    assign shifted_s = 32'(pair_s >> {offset_i, 3'b000});

    // Extend the addressed byte/halfword to a full word.
    always_comb begin
        value_o = shifted_s;
        case (load_type_i)
            LT_LB:   value_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LT_LH:   value_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LT_LBU:  value_o = {24'h000000, shifted_s[7:0]};
            LT_LHU:  value_o = {16'h0000, shifted_s[15:0]};
            default: value_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/data_memory_load_unit.sv
// Data memory load unit: accepts a load, issues one or two word-aligned
// reads to a 1-cycle synchronous memory, formats the result and returns it
// as a registered word with a one-cycle valid strobe.
// Build option: define MISALIGNED_LOAD_EN to service word-spanning loads
// with a second read; otherwise such loads return 0 with misaligned_fault.
module data_memory_load_unit
    import data_memory_load_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              flush,
    input  logic [2:0]        load_type,
    input  logic [ADDR_W-1:0] long_addr,
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  word_t             mem_read_value,
    output word_t             read_value,
    output logic              load_valid,
    output logic              misaligned_fault
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        offset_q, offset_d;
    logic              span_q, span_d;
    word_t             word0_q, word0_d;
    word_t             read_value_q, read_value_d;
    logic              load_valid_q, load_valid_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] word_addr_s;
    logic [2:0]        req_type_s;
    word_t             fmt_word0_s;
    word_t             fmt_word1_s;
    word_t             fmt_value_s;

    assign word_addr_s = {long_addr[ADDR_W-1:2], 2'b00};
    assign req_type_s  = decode_load_type(load_type);

    assign ready            = (state_q == IDLE);
    assign read_value       = read_value_q;
    assign load_valid       = load_valid_q;
    assign misaligned_fault = fault_q;

    // Read address: request word while idle, following word (wrapping) once busy.
    always_comb begin
        case (state_q)
            IDLE:    mem_addr = word_addr_s;
            default: mem_addr = addr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
        endcase
    end

    // Formatter window: second read pairs with the captured first word.
    always_comb begin
        if (state_q == RD1) begin
            fmt_word0_s = word0_q;
            fmt_word1_s = mem_read_value;
        end else begin
            fmt_word0_s = mem_read_value;
            fmt_word1_s = 32'h0000_0000;
        end
    end

    data_memory_load_format u_format (
        .word0_i     (fmt_word0_s),
        .word1_i     (fmt_word1_s),
        .offset_i    (offset_q),
        .load_type_i (type_q),
        .value_o     (fmt_value_s)
    );

    // Load FSM next-state and output-register next values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        type_d       = type_q;
        offset_d     = offset_q;
        span_d       = span_q;
        word0_d      = word0_q;
        read_value_d = read_value_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    state_d  = RD0;
                    addr_d   = word_addr_s;
                    type_d   = req_type_s;
                    offset_d = long_addr[1:0];
                    span_d   = load_spans(req_type_s, long_addr[1:0]);
                end else begin
                    state_d = IDLE;
                end
            end
            RD0: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (span_q) begin
`ifdef MISALIGNED_LOAD_EN
                    state_d = RD1;
                    word0_d = mem_read_value;
`else
                    state_d      = IDLE;
                    read_value_d = 32'h0000_0000;
                    load_valid_d = 1'b1;
                    fault_d      = 1'b1;
`endif
                end else begin
                    state_d      = IDLE;
                    read_value_d = fmt_value_s;
                    load_valid_d = 1'b1;
                end
            end
            RD1: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d      = IDLE;
                    read_value_d = fmt_value_s;
                    load_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            type_q       <= 3'b000;
            offset_q     <= 2'b00;
            span_q       <= 1'b0;
            word0_q      <= 32'h0000_0000;
            read_value_q <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            type_q       <= type_d;
            offset_q     <= offset_d;
            span_q       <= span_d;
            word0_q      <= word0_d;
            read_value_q <= read_value_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

endmodule
